amm_dp_ram: RTL

Dual-port Avalon-MM slave memory that sits directly downstream of the byte-increment engine and serves both of its masters. One port is read-only and feeds the engine's read master; the other is write-only and accepts its byte-enabled writes. It provides pipelined reads with a fixed `readdatavalid` latency, byte-granular writes, and optional waitrequest stall injection, so the engine can be exercised against realistic slave back-pressure.

---
 rtl/amm_dp_ram.sv | 119 +++++++++++
 1 files changed

// File: rtl/amm_dp_ram.sv
// amm_dp_ram: dual-port Avalon-MM RAM (read-only + byte-enabled write port), reads return READ_LATENCY cycles after accept.
// Back-pressure only via waitrequest: one post-reset stall cycle, plus periodic stalls when AMM_DP_RAM_STALL_EN is defined.
module amm_dp_ram #(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 10,
  parameter int BYTE_CNT     = DATA_WIDTH / 8,
  parameter int READ_LATENCY = 2,
  parameter int STALL_PERIOD = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [ADDR_WIDTH-1:0] amm_rd_address_i,
  input  logic                  amm_rd_read_i,
  output logic                  amm_rd_waitrequest_o,
  output logic [DATA_WIDTH-1:0] amm_rd_readdata_o,
  output logic                  amm_rd_readdatavalid_o,
  input  logic [ADDR_WIDTH-1:0] amm_wr_address_i,
  input  logic                  amm_wr_write_i,
  input  logic [DATA_WIDTH-1:0] amm_wr_writedata_i,
  input  logic [BYTE_CNT-1:0]   amm_wr_byteenable_i,
  output logic                  amm_wr_waitrequest_o
);

  localparam int LAT   = READ_LATENCY;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  if (READ_LATENCY < 1 || READ_LATENCY > 4 || (DATA_WIDTH % 8) != 0 ||
      BYTE_CNT != DATA_WIDTH / 8 || STALL_PERIOD < 2 || (STALL_PERIOD % 2) != 0) begin : g_param_chk
    $error("amm_dp_ram: illegal parameter combination");
  end

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic                  r_run;
  logic                  w_rd_stall;
  logic                  w_wr_stall;
  logic                  w_rd_acc;
  logic                  w_wr_acc;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic [LAT-1:0]        r_vld;
  logic [DATA_WIDTH-1:0] r_dat [LAT];

  // Low for the reset cycle and the first edge after release; gates both ports.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

`ifdef AMM_DP_RAM_STALL_EN
  localparam int CW = (STALL_PERIOD > 2) ? $clog2(STALL_PERIOD) : 1;
  localparam logic [CW-1:0] WR_STALL_PH = CW'(STALL_PERIOD - 1);
  localparam logic [CW-1:0] RD_STALL_PH = CW'(STALL_PERIOD / 2 - 1);

  logic [CW-1:0] r_wr_cnt;
  logic [CW-1:0] r_rd_cnt;

  // Counters hold at 0 through the post-reset stall, then free-run.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
    end else if (r_run) begin
      r_wr_cnt <= (r_wr_cnt == WR_STALL_PH) ? '0 : r_wr_cnt + 1'b1;
      r_rd_cnt <= (r_rd_cnt == WR_STALL_PH) ? '0 : r_rd_cnt + 1'b1;
    end
  end

  assign w_wr_stall = (r_wr_cnt == WR_STALL_PH);
  assign w_rd_stall = (r_rd_cnt == RD_STALL_PH);
`else
  assign w_wr_stall = 1'b0;
  assign w_rd_stall = 1'b0;
`endif

  assign amm_wr_waitrequest_o = ~r_run | w_wr_stall;
  assign amm_rd_waitrequest_o = ~r_run | w_rd_stall;

  // rst_n_i term drops a write that coincides with reset assertion.
  assign w_wr_acc  = amm_wr_write_i & ~amm_wr_waitrequest_o & rst_n_i;
  assign w_rd_acc  = amm_rd_read_i & ~amm_rd_waitrequest_o;
  assign w_rd_word = r_mem[amm_rd_address_i];

  always_ff @(posedge clk_i) begin
    if (w_wr_acc) begin
      for (int k = 0; k < BYTE_CNT; k++) begin
        if (amm_wr_byteenable_i[k]) begin
          r_mem[amm_wr_address_i][8*k +: 8] <= amm_wr_writedata_i[8*k +: 8];
        end
      end
    end
  end

  // Stage 0 samples the old word, so a same-edge write is seen only by later reads.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_vld <= '0;
      for (int i = 0; i < LAT; i++) begin
        r_dat[i] <= '0;
      end
    end else begin
      r_vld[0] <= w_rd_acc;
      if (w_rd_acc) begin
        r_dat[0] <= w_rd_word;
      end
      for (int i = 1; i < LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        if (r_vld[i-1]) begin
          r_dat[i] <= r_dat[i-1];
        end
      end
    end
  end

  assign amm_rd_readdatavalid_o = r_vld[LAT-1];
  assign amm_rd_readdata_o      = r_dat[LAT-1];

endmodule
